instruction_ram_loader: RTL

Boot-time writer for the processor's instruction memory, the write side of the word-addressed, 32-bit instruction store that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake.
- Stream format: 16-bit word count, then instruction words, each MSB-first.
- Each assembled word is written to the next sequential RAM address.
- The core is held off (cpuHold) until the image is fully loaded.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 49 ++++
 rtl/instruction_ram_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction RAM loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int LEN_BYTES = 2;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects MSB-first stream bytes into one instruction word and flags the byte that completes it.
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_ready
);
  import loader_pkg::*;

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_byte;

  // Shifting left means the first byte ends up in the top lane after BPW bytes.
  assign word_next  = (word_q << 8) | DATA_WIDTH'(byte_in);
  assign last_byte  = (idx_q == IDX_W'(BPW - 1));
  assign word_ready = byte_en && last_byte;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_en) begin
      word_d = word_next;
      idx_d  = last_byte ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instruction_ram_loader.sv
// Boot loader: parses a length-prefixed byte stream and writes each word to sequential instruction RAM addresses.
module instruction_ram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  ramWriteEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramData,
  output logic                  cpuHold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   wordCount
);
  import loader_pkg::*;

  localparam int LEN_W = 8 * LEN_BYTES;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d, we_q, we_d, hold_q, hold_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  accept, asm_en, asm_clear, word_ready;
  logic [DATA_WIDTH-1:0] word_next;
  logic [LEN_W-1:0]      len_full;

  assign accept   = byteValid && ready_q;
  assign asm_en   = accept && (state_q == ST_DATA);
  assign len_full = {len_q[LEN_W-1:8], byteIn};

  word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_en    (asm_en),
    .byte_in    (byteIn),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          cnt_d   = '0;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {byteIn, len_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          // 17-bit compare keeps DEPTH=65536 representable.
          if (len_full == '0 || {1'b0, len_full} > (LEN_W + 1)'(DEPTH)) begin
            state_d = ST_ERROR;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            asm_clear = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (word_ready) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          data_d  = word_next;
        end
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (((LEN_W + 1)'(cnt_q) + 1'b1) == {1'b0, len_q}) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) || (state_d == ST_DATA);
    busy_d  = ready_d || (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERROR);
    hold_d  = (state_d != ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byteReady      = ready_q;
  assign ramWriteEnable = we_q;
  assign ramAddress     = addr_q;
  assign ramData        = data_q;
  assign cpuHold        = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign wordCount      = cnt_q;

endmodule
